// File: rtl/cache_meta_nway.sv
// cache_meta_nway
// ---------------------------------------------------------------------------
// N-way set-associative metadata array for the L1 caches. Holds {valid, tag}
// per way per set and a tree pseudo-LRU per set. Handles lookup, fill with
// victim selection, single-line invalidate and a multi-cycle flush of every
// set. Every accepted request gets exactly one registered response, one
// cycle after acceptance. A flush responds once, after its last set.
//
// Parameters
//   WAYS   associativity (power of 2, >= 2)
//   SETS   number of sets (power of 2, >= 2)
//   TAG_W  tag width
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset, clears all state
//   req_valid_i      request present
//   req_op_i         00 lookup, 01 fill, 10 invalidate, 11 flush all
//   req_set_i        set index
//   req_tag_i        tag
//   req_ready_o      high in IDLE, low while flushing
//   rsp_valid_o      one-cycle pulse per completed request
//   rsp_hit_o        a valid tag matched at request time
//   rsp_way_o        matching way (hit) or written way (fill miss)
//   rsp_evict_o      fill miss replaced a valid line
//   rsp_evict_tag_o  tag of the replaced line (0 when no eviction)
// ---------------------------------------------------------------------------
module cache_meta_nway #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  parameter  int TAG_W = 6,
  localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1,
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic [1:0]       req_op_i,
  input  logic [SET_W-1:0] req_set_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  output logic             rsp_hit_o,
  output logic [WAY_W-1:0] rsp_way_o,
  output logic             rsp_evict_o,
  output logic [TAG_W-1:0] rsp_evict_tag_o
);

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_FILL   = 2'b01,
    OP_INVAL  = 2'b10,
    OP_FLUSH  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // PLRU node bits are heap indexed 1..WAYS-1; bit 0 of each vector is unused.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  plru_q  [SETS];

  state_e           state_q;
  logic [SET_W-1:0] flush_cnt_q;

  logic             rsp_valid_q;
  logic             rsp_hit_q;
  logic [WAY_W-1:0] rsp_way_q;
  logic             rsp_evict_q;
  logic [TAG_W-1:0] rsp_evict_tag_q;

  // Point every node on way's path away from it: a node whose lower child
  // lies on the path gets 1, otherwise 0.
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAY_W:0]  node;
    logic [WAYS-1:0] res;
    res  = bits;
    node = {1'b1, way};
    for (int l = 0; l < WAY_W; l++) begin
      res[node[WAY_W:1]] = ~node[0];
      node = {1'b0, node[WAY_W:1]};
    end
    return res;
  endfunction

  logic             hit;
  logic [WAY_W-1:0] match_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim_way;

  // Scanning from the top index down lets the lowest index win both the
  // match and the first-invalid search.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    logic [WAY_W:0] node;
    hit       = 1'b0;
    match_way = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set_i][w] && (tag_q[req_set_i][w] == req_tag_i)) begin
        hit       = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!valid_q[req_set_i][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    // Walk from the root. The leaf index ends up as {1, victim}.
    node = (WAY_W + 1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      node = {node[WAY_W-1:0], plru_q[req_set_i][node[WAY_W-1:0]]};
    end
    plru_way   = node[WAY_W-1:0];
    victim_way = inv_found ? inv_way : plru_way;
  end

  // NOTE: the metadata arrays sit on the async reset like any other register:
  // reset must leave every line invalid, and there is no sweep to do it later.
  // NOTE: all sequential state uses non-blocking assignments so every read
  // sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
      state_q         <= ST_IDLE;
      flush_cnt_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            unique case (op_e'(req_op_i))
              OP_LOOKUP: begin
                rsp_valid_q     <= 1'b1;
                rsp_hit_q       <= hit;
                rsp_way_q       <= hit ? match_way : '0;
                rsp_evict_q     <= 1'b0;
                rsp_evict_tag_q <= '0;
                if (hit) plru_q[req_set_i] <= plru_touch(plru_q[req_set_i], match_way);
              end
              OP_FILL: begin
                rsp_valid_q <= 1'b1;
                rsp_hit_q   <= hit;
                if (hit) begin
                  rsp_way_q          <= match_way;
                  rsp_evict_q        <= 1'b0;
                  rsp_evict_tag_q    <= '0;
                  plru_q[req_set_i]  <= plru_touch(plru_q[req_set_i], match_way);
                end else begin
                  rsp_way_q       <= victim_way;
                  rsp_evict_q     <= valid_q[req_set_i][victim_way];
                  rsp_evict_tag_q <= valid_q[req_set_i][victim_way]
                                     ? tag_q[req_set_i][victim_way] : '0;
                  valid_q[req_set_i][victim_way] <= 1'b1;
                  tag_q[req_set_i][victim_way]   <= req_tag_i;
                  plru_q[req_set_i] <= plru_touch(plru_q[req_set_i], victim_way);
                end
              end
              OP_INVAL: begin
                rsp_valid_q     <= 1'b1;
                rsp_hit_q       <= hit;
                rsp_way_q       <= hit ? match_way : '0;
                rsp_evict_q     <= 1'b0;
                rsp_evict_tag_q <= '0;
                if (hit) valid_q[req_set_i][match_way] <= 1'b0;
              end
              OP_FLUSH: begin
                state_q     <= ST_FLUSH;
                flush_cnt_q <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          valid_q[flush_cnt_q] <= '0;
          plru_q[flush_cnt_q]  <= '0;
          flush_cnt_q          <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == SET_W'(SETS - 1)) begin
            state_q         <= ST_IDLE;
            rsp_valid_q     <= 1'b1;
            rsp_hit_q       <= 1'b0;
            rsp_way_q       <= '0;
            rsp_evict_q     <= 1'b0;
            rsp_evict_tag_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_way_o       = rsp_way_q;
  assign rsp_evict_o     = rsp_evict_q;
  assign rsp_evict_tag_o = rsp_evict_tag_q;

endmodule

// File: tb/tb_cache_meta_nway.sv
// Testbench for cache_meta_nway. Instance "a" is the default 2-way, 64-set
// configuration; instance "b" is 4-way, 4-set to exercise the PLRU tree.
module tb_cache_meta_nway;

  logic clk;
  logic rst_n;

  // Instance a: WAYS=2, SETS=64, TAG_W=6
  logic       a_valid;
  logic [1:0] a_op;
  logic [5:0] a_set;
  logic [5:0] a_tag;
  logic       a_ready, a_rsp_valid, a_rsp_hit, a_rsp_evict;
  logic [0:0] a_rsp_way;
  logic [5:0] a_rsp_etag;

  // Instance b: WAYS=4, SETS=4, TAG_W=6
  logic       b_valid;
  logic [1:0] b_op;
  logic [1:0] b_set;
  logic [5:0] b_tag;
  logic       b_ready, b_rsp_valid, b_rsp_hit, b_rsp_evict;
  logic [1:0] b_rsp_way;
  logic [5:0] b_rsp_etag;

  int n_checks;
  int n_fail;

  cache_meta_nway #(.WAYS(2), .SETS(64), .TAG_W(6)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_valid), .req_op_i(a_op), .req_set_i(a_set), .req_tag_i(a_tag),
    .req_ready_o(a_ready), .rsp_valid_o(a_rsp_valid), .rsp_hit_o(a_rsp_hit),
    .rsp_way_o(a_rsp_way), .rsp_evict_o(a_rsp_evict), .rsp_evict_tag_o(a_rsp_etag)
  );

  cache_meta_nway #(.WAYS(4), .SETS(4), .TAG_W(6)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_valid), .req_op_i(b_op), .req_set_i(b_set), .req_tag_i(b_tag),
    .req_ready_o(b_ready), .rsp_valid_o(b_rsp_valid), .rsp_hit_o(b_rsp_hit),
    .rsp_way_o(b_rsp_way), .rsp_evict_o(b_rsp_evict), .rsp_evict_tag_o(b_rsp_etag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         b;     // 0: instance a, 1: instance b
    logic [1:0] op;
    logic [5:0] set;
    logic [5:0] tag;
    logic       hit;
    logic [1:0] way;
    logic       ev;
    logic [5:0] etag;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];
  vec_t tbl3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit b, logic [1:0] op, logic [5:0] set, logic [5:0] tag,
                              logic hit, logic [1:0] way, logic ev, logic [5:0] etag);
    vec_t v;
    v.b = b; v.op = op; v.set = set; v.tag = tag;
    v.hit = hit; v.way = way; v.ev = ev; v.etag = etag;
    return v;
  endfunction

  // Drive one request for a single cycle, then sample #1 after the edge.
  task automatic issue(input bit b, input logic [1:0] op, input logic [5:0] set,
                       input logic [5:0] tag);
    if (!b) begin
      a_valid = 1'b1; a_op = op; a_set = set; a_tag = tag;
    end else begin
      b_valid = 1'b1; b_op = op; b_set = set[1:0]; b_tag = tag;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string id);
    logic       rv, rh, re;
    logic [1:0] rw;
    logic [5:0] rt;
    issue(v.b, v.op, v.set, v.tag);
    if (!v.b) begin
      rv = a_rsp_valid; rh = a_rsp_hit; rw = {1'b0, a_rsp_way}; re = a_rsp_evict; rt = a_rsp_etag;
    end else begin
      rv = b_rsp_valid; rh = b_rsp_hit; rw = b_rsp_way; re = b_rsp_evict; rt = b_rsp_etag;
    end
    check({id, "_valid"}, 32'(rv), 32'd1);
    check({id, "_hit"},   32'(rh), 32'(v.hit));
    check({id, "_way"},   32'(rw), 32'(v.way));
    check({id, "_evict"}, 32'(re), 32'(v.ev));
    check({id, "_etag"},  32'(rt), 32'(v.etag));
  endtask

  initial begin
    int k;
    int low;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    a_valid = 1'b0; a_op = '0; a_set = '0; a_tag = '0;
    b_valid = 1'b0; b_op = '0; b_set = '0; b_tag = '0;

    //            b  op set    tag    hit way ev etag
    tbl1.push_back(mk(0, 0, 6'd5, 6'h2A, 0, 0, 0, 6'h00)); // cold miss
    tbl1.push_back(mk(0, 1, 6'd5, 6'h2A, 0, 0, 0, 6'h00));
    tbl1.push_back(mk(0, 1, 6'd5, 6'h15, 0, 1, 0, 6'h00));
    tbl1.push_back(mk(0, 0, 6'd5, 6'h2A, 1, 0, 0, 6'h00)); // touches way 0
    tbl1.push_back(mk(0, 1, 6'd5, 6'h3F, 0, 1, 1, 6'h15)); // LRU victim way 1
    tbl1.push_back(mk(0, 1, 6'd5, 6'h15, 0, 0, 1, 6'h2A));
    tbl1.push_back(mk(0, 0, 6'd5, 6'h15, 1, 0, 0, 6'h00));
    tbl1.push_back(mk(0, 2, 6'd5, 6'h3F, 1, 1, 0, 6'h00)); // invalidate way 1
    tbl1.push_back(mk(0, 1, 6'd5, 6'h01, 0, 1, 0, 6'h00)); // fills freed way
    tbl1.push_back(mk(0, 0, 6'd5, 6'h15, 1, 0, 0, 6'h00)); // LRU now way 1
    tbl1.push_back(mk(0, 2, 6'd5, 6'h15, 1, 0, 0, 6'h00));
    tbl1.push_back(mk(0, 1, 6'd5, 6'h22, 0, 0, 0, 6'h00)); // invalid beats PLRU
    tbl1.push_back(mk(0, 2, 6'd5, 6'h3F, 0, 0, 0, 6'h00)); // invalidate miss
    tbl1.push_back(mk(0, 0, 6'd6, 6'h22, 0, 0, 0, 6'h00)); // other set
    tbl1.push_back(mk(0, 1, 6'd6, 6'h22, 0, 0, 0, 6'h00));
    tbl1.push_back(mk(0, 0, 6'd5, 6'h22, 1, 0, 0, 6'h00));
    tbl1.push_back(mk(0, 1, 6'd5, 6'h01, 1, 1, 0, 6'h00)); // fill hit
    // 4-way tree PLRU
    tbl1.push_back(mk(1, 1, 6'd0, 6'd1, 0, 0, 0, 6'd0));
    tbl1.push_back(mk(1, 1, 6'd0, 6'd2, 0, 1, 0, 6'd0));
    tbl1.push_back(mk(1, 1, 6'd0, 6'd3, 0, 2, 0, 6'd0));
    tbl1.push_back(mk(1, 1, 6'd0, 6'd4, 0, 3, 0, 6'd0));
    tbl1.push_back(mk(1, 0, 6'd0, 6'd1, 1, 0, 0, 6'd0)); // root=1 node2=1 node3=0
    tbl1.push_back(mk(1, 1, 6'd0, 6'd5, 0, 2, 1, 6'd3));
    tbl1.push_back(mk(1, 1, 6'd0, 6'd6, 0, 1, 1, 6'd2));
    tbl1.push_back(mk(1, 1, 6'd0, 6'd7, 0, 3, 1, 6'd4));

    tbl2.push_back(mk(0, 0, 6'd5,  6'h01, 0, 0, 0, 6'h00));
    tbl2.push_back(mk(0, 0, 6'd6,  6'h22, 0, 0, 0, 6'h00));
    tbl2.push_back(mk(0, 0, 6'd5,  6'h33, 0, 0, 0, 6'h00)); // ignored fill not written
    tbl2.push_back(mk(0, 1, 6'd5,  6'h44, 0, 0, 0, 6'h00));
    tbl2.push_back(mk(0, 1, 6'd63, 6'h3F, 0, 0, 0, 6'h00));

    tbl3.push_back(mk(0, 0, 6'd63, 6'h3F, 0, 0, 0, 6'h00));
    tbl3.push_back(mk(0, 0, 6'd5,  6'h44, 0, 0, 0, 6'h00));
    tbl3.push_back(mk(0, 1, 6'd5,  6'h10, 0, 0, 0, 6'h00));
    tbl3.push_back(mk(1, 0, 6'd0,  6'd5,  0, 0, 0, 6'd0));

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_hit",   32'(a_rsp_hit),   32'd0);
    check("rst_way",   32'(a_rsp_way),   32'd0);
    check("rst_evict", 32'(a_rsp_evict), 32'd0);
    check("rst_etag",  32'(a_rsp_etag),  32'd0);
    check("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(a_ready), 32'd1);

    foreach (tbl1[i]) run_vec(tbl1[i], $sformatf("t1_%0d", i));
    check("t1_ready", 32'(a_ready), 32'd1);

    // rsp_valid is a single pulse; the other response fields hold
    @(posedge clk);
    #1;
    check("pulse_valid", 32'(a_rsp_valid), 32'd0);
    check("pulse_hold_hit", 32'(a_rsp_hit), 32'd1);
    check("pulse_hold_way", 32'(a_rsp_way), 32'd1);

    // Full flush with a fill request held throughout (must be ignored)
    issue(0, 2'd3, 6'd0, 6'd0);
    check("fl_acc_valid", 32'(a_rsp_valid), 32'd0);
    low = a_ready ? 0 : 1;
    a_valid = 1'b1; a_op = 2'd1; a_set = 6'd5; a_tag = 6'h33;
    k = 0;
    while (!a_rsp_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (!a_ready) low++;
    end
    a_valid = 1'b0;
    check("fl_done_cycles", 32'(k), 32'd64);
    check("fl_ready_low",   32'(low), 32'd64);
    check("fl_ready_back",  32'(a_ready), 32'd1);
    check("fl_done_hit",    32'(a_rsp_hit), 32'd0);
    check("fl_done_way",    32'(a_rsp_way), 32'd0);
    check("fl_done_evict",  32'(a_rsp_evict), 32'd0);
    @(posedge clk);
    #1;
    check("fl_pulse_end", 32'(a_rsp_valid), 32'd0);

    foreach (tbl2[i]) run_vec(tbl2[i], $sformatf("t2_%0d", i));

    // Flush interrupted by reset at cycle 10
    issue(0, 2'd3, 6'd0, 6'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rf_ready_low", 32'(a_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rf_rst_valid", 32'(a_rsp_valid), 32'd0);
    check("rf_rst_hit",   32'(a_rsp_hit),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (a_rsp_valid) pulses++;
    end
    check("rf_no_done", 32'(pulses), 32'd0);
    check("rf_ready",   32'(a_ready), 32'd1);

    foreach (tbl3[i]) run_vec(tbl3[i], $sformatf("t3_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
